riscv_execute_alu: RTL
======================

Name: riscv_execute_alu

Overview:
- RV32I execute-stage ALU. It consumes the operands and control captured by the ID/EX pipeline register and produces a registered result for the EX/MEM stage.
- Arithmetic, logic and compare ops complete in 1 cycle.
- Shifts use an area-saving iterative 1-bit-per-cycle shifter. While it runs, o_stall holds the upstream pipeline.

Parameters:
- XLEN, 32, datapath width. Shift amount is i_src_b[4:0]; only 32 is supported.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  reset; asynchronous, active-low
- i_valid  input  1  operation present on inputs this cycle
- i_flush  input  1  synchronous kill of current/incoming op
- i_alu_ctrl  input  4  op select, encoded below
- i_src_a  input  XLEN  operand A
- i_src_b  input  XLEN  operand B / shift amount
- i_rd_addr  input  5  destination register tag
- o_result  output  XLEN  registered result
- o_rd_addr  output  5  tag of o_result
- o_valid  output  1  one-cycle pulse: o_result/o_rd_addr valid
- o_stall  output  1  unit busy; upstream must hold

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI).
  - Codes 11-15 are accepted and produce result 0.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. SLT is a signed compare and SLTU is unsigned; both give result 1 or 0, zero-extended.
- Reset (async, i_rstn=0):
  - state=IDLE.
  - o_result=0, o_rd_addr=0, o_valid=0, o_stall=0.
  - Shift accumulator and counter = 0.
  - Applies immediately, including mid-shift.
- State machine: two states, IDLE and SHIFT. o_stall = (state==SHIFT), decoded from the state register.
- IDLE, i_valid=1, i_flush=0, non-shift op:
  - The next edge loads o_result=f(A,B), o_rd_addr=i_rd_addr, o_valid=1.
  - Latency 1; a new op can be accepted every cycle.
- IDLE, i_valid=1, shift op (2/6/7), shamt=i_src_b[4:0]:
  - shamt==0: handled as a 1-cycle op with result=i_src_a.
  - shamt!=0: the unit captures acc=i_src_a, cnt=shamt, op and rd tag; o_valid=0; next state SHIFT.
- SHIFT, each cycle:
  - acc shifts by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, fill with acc[XLEN-1]), and cnt decrements.
  - When cnt==1, the shifted value loads o_result, the tag loads o_rd_addr, o_valid=1, and next state is IDLE.
  - Result valid shamt cycles after acceptance; o_stall is high for exactly shamt cycles.
- i_valid while in SHIFT is ignored. Upstream holds its op because of o_stall.
- Back-to-back: the cycle the FSM returns to IDLE (o_stall=0), a new op may be accepted.
- o_valid defaults to 0 on every edge where no result completes. It is never high for 2 cycles from the same op.
- o_result/o_rd_addr hold their last value when o_valid=0.
- i_flush=1 (any state):
  - Next state is IDLE, o_valid=0, cnt=0.
  - o_result/o_rd_addr are unchanged.
  - Flush wins over a simultaneous i_valid and over a completing shift (no o_valid that cycle).
- i_flush and i_rstn never create X on outputs.

Optional Feature:
- Macro RISCV_BARREL_SHIFT_EN.
- Defined:
  - Shifts are computed combinationally in one cycle (latency 1, like ADD).
  - SHIFT state and counter are not built; o_stall is tied to 0.
- Undefined: iterative shifter as described above.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
1. ADD A=0x7FFFFFFF, B=1, rd=5 -> next cycle o_result=0x80000000, o_rd_addr=5, o_valid pulse, o_stall=0. SUB 0-1 -> 0xFFFFFFFF. SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0.
2. SLL A=1, B=5, rd=3, with i_valid held and ADD on inputs during the stall -> o_stall high 5 cycles; o_valid pulses on 5th edge after accept with 0x00000020, rd=3; ADD result appears the cycle after stall drops. With RISCV_BARREL_SHIFT_EN: 0x20 after 1 cycle, o_stall never high.
3. SRA A=0x80000000, B=31 -> 0xFFFFFFFF after 31 cycles; SRL same operands -> 0x00000001; SLL B=0x00000020 (shamt 0) -> result=A in 1 cycle, no stall.
4. Flush during SHIFT: SRL A=0xF0000000, B=8; assert i_flush on the 3rd stall cycle -> o_stall low next cycle, no o_valid, o_result retains prior value; ADD 2+3 issued next -> 5.
5. Flush coincident with i_valid in IDLE -> no o_valid; flush on the completing cycle of a shift (cnt==1) -> no o_valid.
6. Reset asserted mid-shift (SLL B=20, cycle 10) -> o_result=0, o_rd_addr=0, o_valid=0, o_stall=0 immediately; after release, AND 0xFF00FF00 & 0x0FF00FF0 -> 0x0F000F00 in 1 cycle.

Source files
------------

// File: rtl/riscv_execute_alu.sv
// RV32I execute-stage ALU with a registered result for EX/MEM.
// Shifts are iterative (1 bit/cycle, o_stall held) unless RISCV_BARREL_SHIFT_EN is defined.
module riscv_execute_alu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    input  logic            i_flush,
    input  logic [3:0]      i_alu_ctrl,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic [4:0]      i_rd_addr,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr,
    output logic            o_valid,
    output logic            o_stall
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0]      op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic [XLEN-1:0]        r;
`ifdef RISCV_BARREL_SHIFT_EN
        logic [4:0]             shamt;
        shamt = b[4:0];
`endif
        a_s = a;
        b_s = b;
        r   = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_PASS: r = b;
`ifdef RISCV_BARREL_SHIFT_EN
            OP_SLL:  r = a << shamt;
            OP_SRL:  r = a >> shamt;
            OP_SRA:  r = a_s >>> shamt;
`else
            // Only reached with a zero shift amount; nonzero amounts iterate.
            OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef RISCV_BARREL_SHIFT_EN

    logic [XLEN-1:0] res_nxt;
    logic [4:0]      rd_nxt;
    logic            vld_nxt;

    always_comb begin
        res_nxt = o_result;
        rd_nxt  = o_rd_addr;
        vld_nxt = 1'b0;
        if (!i_flush && i_valid) begin
            res_nxt = alu_f(i_alu_ctrl, i_src_a, i_src_b);
            rd_nxt  = i_rd_addr;
            vld_nxt = 1'b1;
        end
    end

    // result register stage
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_result  <= '0;
            o_rd_addr <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_result  <= res_nxt;
            o_rd_addr <= rd_nxt;
            o_valid   <= vld_nxt;
        end
    end

    assign o_stall = 1'b0;

`else

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic [XLEN-1:0] shift1(input logic [3:0]      op,
                                               input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (op)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = {1'b0, v[XLEN-1:1]};
        endcase
        return r;
    endfunction

    state_t          state_p1, state_nxt;
    logic [XLEN-1:0] acc_p1, acc_nxt;
    logic [4:0]      cnt_p1, cnt_nxt;
    logic [3:0]      op_p1, op_nxt;
    logic [4:0]      rd_p1, rd_hold_nxt;
    logic [XLEN-1:0] res_nxt;
    logic [4:0]      rd_nxt;
    logic            vld_nxt;
    logic [XLEN-1:0] acc_shifted;

    assign acc_shifted = shift1(op_p1, acc_p1);

    always_comb begin
        state_nxt   = state_p1;
        acc_nxt     = acc_p1;
        cnt_nxt     = cnt_p1;
        op_nxt      = op_p1;
        rd_hold_nxt = rd_p1;
        res_nxt     = o_result;
        rd_nxt      = o_rd_addr;
        vld_nxt     = 1'b0;
        if (i_flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state_p1)
                IDLE: begin
                    if (i_valid) begin
                        if (is_shift(i_alu_ctrl) && (i_src_b[4:0] != 5'd0)) begin
                            acc_nxt     = i_src_a;
                            cnt_nxt     = i_src_b[4:0];
                            op_nxt      = i_alu_ctrl;
                            rd_hold_nxt = i_rd_addr;
                            state_nxt   = SHIFT;
                        end else begin
                            res_nxt = alu_f(i_alu_ctrl, i_src_a, i_src_b);
                            rd_nxt  = i_rd_addr;
                            vld_nxt = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    acc_nxt = acc_shifted;
                    cnt_nxt = cnt_p1 - 5'd1;
                    if (cnt_p1 == 5'd1) begin
                        res_nxt   = acc_shifted;
                        rd_nxt    = rd_p1;
                        vld_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // shifter state and result register stage
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_p1  <= IDLE;
            acc_p1    <= '0;
            cnt_p1    <= '0;
            op_p1     <= '0;
            rd_p1     <= '0;
            o_result  <= '0;
            o_rd_addr <= '0;
            o_valid   <= 1'b0;
        end else begin
            state_p1  <= state_nxt;
            acc_p1    <= acc_nxt;
            cnt_p1    <= cnt_nxt;
            op_p1     <= op_nxt;
            rd_p1     <= rd_hold_nxt;
            o_result  <= res_nxt;
            o_rd_addr <= rd_nxt;
            o_valid   <= vld_nxt;
        end
    end

    assign o_stall = (state_p1 == SHIFT);

`endif

endmodule
